xgs_hispi_line_tx: RTL and testbench

- HiSPi Packetized-SP line transmitter. It is the sensor-side counterpart of the XGS HiSPi receiver/deserializer path in the athena controller.
- Takes a stream of parallel pixel words, one 12-bit word per lane per beat. Frames them into per-lane HiSPi words: SOF/SOL sync, active data, EOF/EOL sync, horizontal blanking idles.
- Used as a synthesizable XGS sensor emulator in validation and loopback builds, driving the receiver's lane word inputs ahead of the serializer.

---
 rtl/xgs_hispi_line_tx.sv | 224 ++++++++++++++++++++++
 tb/tb_xgs_hispi_line_tx.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/xgs_hispi_line_tx.sv
// HiSPi Packetized-SP line transmitter: frames parallel pixel beats into per-lane sync/data/blank words.
// Optional per-line XOR check word after the end sync is enabled with XGS_HISPI_TX_CRC_EN.
module xgs_hispi_line_tx #(
  parameter int                    NUMBER_OF_LANE = 6,
  parameter int                    LANE_WIDTH     = 12,
  parameter logic [LANE_WIDTH-1:0] IDLE_CODE      = LANE_WIDTH'(12'h3A6)
) (
  input  logic                                 sclk,
  input  logic                                 sclk_reset,
  input  logic                                 cmd_start,
  input  logic [11:0]                          cfg_lines,
  input  logic [9:0]                           cfg_words,
  input  logic [7:0]                           cfg_hblank,
  input  logic [NUMBER_OF_LANE*LANE_WIDTH-1:0] pix_data,
  input  logic                                 pix_valid,
  output logic                                 pix_ready,
  output logic [NUMBER_OF_LANE*LANE_WIDTH-1:0] lane_data,
  output logic                                 busy,
  output logic                                 frame_done,
  output logic                                 underrun,
  output logic [2:0]                           dbg_state
);
  localparam int BW = NUMBER_OF_LANE * LANE_WIDTH;
  localparam logic [LANE_WIDTH-1:0] C_FFF = LANE_WIDTH'(12'hFFF);
  localparam logic [LANE_WIDTH-1:0] C_SOF = LANE_WIDTH'(12'hC00);
  localparam logic [LANE_WIDTH-1:0] C_SOL = LANE_WIDTH'(12'h800);
  localparam logic [LANE_WIDTH-1:0] C_EOF = LANE_WIDTH'(12'hE00);
  localparam logic [LANE_WIDTH-1:0] C_EOL = LANE_WIDTH'(12'hA00);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC_S, S_DATA, S_SYNC_E,
`ifdef XGS_HISPI_TX_CRC_EN
    S_CRC,
`endif
    S_BLANK, S_DONE
  } state_t;

  state_t          r_state, w_state_nxt, w_end_state;
  logic [1:0]      r_sidx, w_sidx_nxt;
  logic [9:0]      r_cnt, w_cnt_nxt;
  logic [11:0]     r_line, w_line_nxt, w_end_line;
  logic [11:0]     r_lines;
  logic [9:0]      r_words;
  logic [7:0]      r_hblank;
  logic [BW-1:0]   r_lane, w_lane_nxt;
  logic [LANE_WIDTH-1:0] w_word;
  logic            r_busy, r_done, r_under;
  logic            w_last, w_line_end, w_use_pix, w_accept;
  logic            w_busy_nxt, w_done_nxt, w_under_set;
`ifdef XGS_HISPI_TX_CRC_EN
  logic [BW-1:0]   r_crc;
  logic            w_crc_clr, w_crc_acc, w_use_crc;
`endif

  function automatic logic [LANE_WIDTH-1:0] f_sync(input logic [1:0] idx,
                                                   input logic [LANE_WIDTH-1:0] code);
    case (idx)
      2'd0:    return C_FFF;
      2'd3:    return code;
      default: return '0;
    endcase
  endfunction

  // The state register leads lane_data by one cycle: each state decides the word
  // registered onto the lanes at the next edge.
  // pix_data is consumed on a cycle where pix_ready && pix_valid; pix_ready depends only on state.
  assign w_last      = (r_line == r_lines - 12'd1);
  assign w_end_state = w_last ? S_DONE : ((r_hblank == 8'd0) ? S_SYNC_S : S_BLANK);
  assign w_end_line  = (!w_last && r_hblank == 8'd0) ? r_line + 12'd1 : r_line;

  always_comb begin
    w_state_nxt = r_state;
    w_sidx_nxt  = r_sidx;
    w_cnt_nxt   = r_cnt;
    w_line_nxt  = r_line;
    w_word      = IDLE_CODE;
    w_use_pix   = 1'b0;
    w_accept    = 1'b0;
    w_line_end  = 1'b0;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_under_set = 1'b0;
    pix_ready   = 1'b0;
`ifdef XGS_HISPI_TX_CRC_EN
    w_crc_clr   = 1'b0;
    w_crc_acc   = 1'b0;
    w_use_crc   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (cmd_start && cfg_lines != 12'd0 && cfg_words != 10'd0) begin
          w_accept    = 1'b1;
          w_word      = C_FFF;
          w_state_nxt = S_SYNC_S;
          w_sidx_nxt  = 2'd1;
          w_cnt_nxt   = '0;
          w_line_nxt  = '0;
          w_busy_nxt  = 1'b1;
        end
      end
      S_SYNC_S: begin
`ifdef XGS_HISPI_TX_CRC_EN
        w_crc_clr  = 1'b1;
`endif
        w_word     = f_sync(r_sidx, (r_line == 12'd0) ? C_SOF : C_SOL);
        w_sidx_nxt = r_sidx + 2'd1;
        if (r_sidx == 2'd3) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = '0;
        end
      end
      S_DATA: begin
        pix_ready = 1'b1;
        if (pix_valid) begin
          w_use_pix = 1'b1;
`ifdef XGS_HISPI_TX_CRC_EN
          w_crc_acc = 1'b1;
`endif
          if (r_cnt == r_words - 10'd1) begin
            w_state_nxt = S_SYNC_E;
            w_sidx_nxt  = 2'd0;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 10'd1;
          end
        end else begin
          w_under_set = 1'b1;
        end
      end
      S_SYNC_E: begin
        w_word     = f_sync(r_sidx, w_last ? C_EOF : C_EOL);
        w_sidx_nxt = r_sidx + 2'd1;
        if (r_sidx == 2'd3) begin
`ifdef XGS_HISPI_TX_CRC_EN
          w_state_nxt = S_CRC;
`else
          w_line_end  = 1'b1;
`endif
        end
      end
`ifdef XGS_HISPI_TX_CRC_EN
      S_CRC: begin
        w_use_crc  = 1'b1;
        w_line_end = 1'b1;
      end
`endif
      S_BLANK: begin
        if (r_cnt == 10'(r_hblank) - 10'd1) begin
          w_state_nxt = S_SYNC_S;
          w_sidx_nxt  = 2'd0;
          w_cnt_nxt   = '0;
          w_line_nxt  = r_line + 12'd1;
        end else begin
          w_cnt_nxt = r_cnt + 10'd1;
        end
      end
      S_DONE: begin
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_line_end) begin
      w_state_nxt = w_end_state;
      w_line_nxt  = w_end_line;
      w_sidx_nxt  = 2'd0;
      w_cnt_nxt   = '0;
    end

    w_lane_nxt = {NUMBER_OF_LANE{w_word}};
    if (w_use_pix) w_lane_nxt = pix_data;
`ifdef XGS_HISPI_TX_CRC_EN
    if (w_use_crc) w_lane_nxt = r_crc;
`endif
  end

  always_ff @(posedge sclk) begin
    if (sclk_reset) begin
      r_state  <= S_IDLE;
      r_sidx   <= '0;
      r_cnt    <= '0;
      r_line   <= '0;
      r_lines  <= '0;
      r_words  <= '0;
      r_hblank <= '0;
      r_lane   <= {NUMBER_OF_LANE{IDLE_CODE}};
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_under  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sidx  <= w_sidx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_line  <= w_line_nxt;
      r_lane  <= w_lane_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      if (w_accept) begin
        r_lines  <= cfg_lines;
        r_words  <= cfg_words;
        r_hblank <= cfg_hblank;
        r_under  <= 1'b0;
      end else if (w_under_set) begin
        r_under <= 1'b1;
      end
    end
  end

`ifdef XGS_HISPI_TX_CRC_EN
  // Stalled beats never reach w_crc_acc, so underrun idles stay out of the check word.
  always_ff @(posedge sclk) begin
    if (sclk_reset || w_crc_clr) r_crc <= '0;
    else if (w_crc_acc)          r_crc <= r_crc ^ pix_data;
  end
`endif

  assign lane_data  = r_lane;
  assign busy       = r_busy;
  assign frame_done = r_done;
  assign underrun   = r_under;
  assign dbg_state  = r_state;
endmodule

// File: tb/tb_xgs_hispi_line_tx.sv
// Directed table-driven bench for xgs_hispi_line_tx; follows XGS_HISPI_TX_CRC_EN when defined.
module tb_xgs_hispi_line_tx;
  localparam logic [11:0] IDLE = 12'h3A6;

  logic        sclk = 1'b0;
  logic        sclk_reset = 1'b1;
  logic        cmd_start = 1'b0;
  logic        pix_valid = 1'b0;
  logic [11:0] cfg_lines;
  logic [9:0]  cfg_words;
  logic [7:0]  cfg_hblank;
  logic [71:0] pix_data;
  logic        pix_ready, busy, frame_done, underrun;
  logic [71:0] lane_data;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        start;
    logic        valid;
    logic [71:0] pix;
    logic [71:0] exp;
    logic        dst;
    logic        busy;
    logic        done;
    logic        under;
  } vec_t;
  vec_t tbl[$];

  xgs_hispi_line_tx dut (
    .sclk(sclk), .sclk_reset(sclk_reset), .cmd_start(cmd_start),
    .cfg_lines(cfg_lines), .cfg_words(cfg_words), .cfg_hblank(cfg_hblank),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .lane_data(lane_data), .busy(busy), .frame_done(frame_done),
    .underrun(underrun), .dbg_state(dbg_state)
  );

  // clock/reset
  always #5 sclk = ~sclk;

  function automatic logic [71:0] rep(input logic [11:0] w);
    return {6{w}};
  endfunction

  function automatic logic [71:0] mk_pix(input int l, input int b);
    logic [71:0] r;
    for (int k = 0; k < 6; k++) r[k*12 +: 12] = 12'(256 + k + 16*b + 256*l);
    return r;
  endfunction

  task automatic chk(input string nm, input int row, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%h want=%h", nm, row, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic vl, input logic [71:0] px, input logic [71:0] ex,
                     input logic ds, input logic bz, input logic dn, input logic un);
    vec_t v;
    v.start = st; v.valid = vl; v.pix = px; v.exp = ex;
    v.dst = ds; v.busy = bz; v.done = dn; v.under = un;
    tbl.push_back(v);
  endtask

  task automatic add_sync(input logic st, input logic [11:0] code, input logic un);
    add(st,   1'b1, '0, rep(12'hFFF), 1'b0, 1'b1, 1'b0, un);
    add(1'b0, 1'b1, '0, rep(12'h000), 1'b0, 1'b1, 1'b0, un);
    add(1'b0, 1'b1, '0, rep(12'h000), 1'b0, 1'b1, 1'b0, un);
    add(1'b0, 1'b1, '0, rep(code),    1'b0, 1'b1, 1'b0, un);
  endtask

  // Expected cycle-by-cycle frame: one row per output cycle, row 0 carries cmd_start.
  task automatic build_frame(input int lines, input int words, input int hb,
                             input int stall_after, input int nstall);
    logic        un;
    logic [71:0] acc;
    un = 1'b0;
    tbl.delete();
    for (int l = 0; l < lines; l++) begin
      add_sync(l == 0, (l == 0) ? 12'hC00 : 12'h800, un);
      acc = '0;
      for (int b = 0; b < words; b++) begin
        if (l == 0 && b == stall_after) begin
          for (int s = 0; s < nstall; s++) begin
            un = 1'b1;
            add(1'b0, 1'b0, '0, rep(IDLE), 1'b1, 1'b1, 1'b0, un);
          end
        end
        add(1'b0, 1'b1, mk_pix(l, b), mk_pix(l, b), 1'b1, 1'b1, 1'b0, un);
        acc = acc ^ mk_pix(l, b);
      end
      add_sync(1'b0, (l == lines - 1) ? 12'hE00 : 12'hA00, un);
`ifdef XGS_HISPI_TX_CRC_EN
      add(1'b0, 1'b1, '0, acc, 1'b0, 1'b1, 1'b0, un);
`endif
      if (l != lines - 1)
        for (int h = 0; h < hb; h++) add(1'b0, 1'b1, '0, rep(IDLE), 1'b0, 1'b1, 1'b0, un);
    end
    add(1'b0, 1'b0, '0, rep(IDLE), 1'b0, 1'b0, 1'b1, un);
    add(1'b0, 1'b0, '0, rep(IDLE), 1'b0, 1'b0, 1'b0, un);
  endtask

  // driver: apply row inputs, clock, check registered outputs #1 later
  task automatic run_tbl(input int n);
    logic exp_rdy;
    for (int i = 0; i < n; i++) begin
      cmd_start = tbl[i].start;
      pix_valid = tbl[i].valid;
      pix_data  = tbl[i].pix;
      @(posedge sclk); #1;
      exp_rdy = (i + 1 < tbl.size()) ? tbl[i+1].dst : 1'b0;
      chk("lane",  i, lane_data,  tbl[i].exp);
      chk("busy",  i, 72'(busy),       72'(tbl[i].busy));
      chk("done",  i, 72'(frame_done), 72'(tbl[i].done));
      chk("under", i, 72'(underrun),   72'(tbl[i].under));
      chk("ready", i, 72'(pix_ready),  72'(exp_rdy));
    end
    cmd_start = 1'b0;
    pix_valid = 1'b0;
  endtask

  task automatic chk_idle(input string nm, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge sclk); #1;
      cmd_start = 1'b0;
      chk({nm, "_lane"},  i, lane_data, rep(IDLE));
      chk({nm, "_busy"},  i, 72'(busy), 72'(0));
      chk({nm, "_ready"}, i, 72'(pix_ready), 72'(0));
      chk({nm, "_done"},  i, 72'(frame_done), 72'(0));
    end
  endtask

  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog row=0 got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    cfg_lines = 12'd2; cfg_words = 10'd4; cfg_hblank = 8'd3; pix_data = '0;
    repeat (3) @(posedge sclk);
    #1;
    chk("rst_lane",  0, lane_data, rep(IDLE));
    chk("rst_state", 0, 72'(dbg_state), 72'(0));
    chk("rst_under", 0, 72'(underrun), 72'(0));
    sclk_reset = 1'b0;
    chk_idle("idle", 20);

    // two-line frame, data always valid
    build_frame(2, 4, 3, -1, 0);
    run_tbl(tbl.size());

    // two stalled beats in line 0
    build_frame(2, 4, 3, 2, 2);
    run_tbl(tbl.size());

    // accepted start clears underrun; starts while busy and in DONE are ignored
    build_frame(2, 4, 3, -1, 0);
    tbl[5].start = 1'b1;
    tbl[12].start = 1'b1;
    tbl[tbl.size()-2].start = 1'b1;
    run_tbl(tbl.size());

    cfg_lines = 12'd0; cmd_start = 1'b1;
    chk_idle("lines0", 3);
    cfg_lines = 12'd2; cfg_words = 10'd0; cmd_start = 1'b1;
    chk_idle("words0", 3);
    cfg_words = 10'd4;

    // reset during line 1 data, then a fresh full frame
    build_frame(2, 4, 3, -1, 0);
    run_tbl(21);
    sclk_reset = 1'b1; pix_valid = 1'b1;
    @(posedge sclk); #1;
    sclk_reset = 1'b0; pix_valid = 1'b0;
    chk("abort_lane",  0, lane_data, rep(IDLE));
    chk("abort_busy",  0, 72'(busy), 72'(0));
    chk("abort_done",  0, 72'(frame_done), 72'(0));
    chk("abort_ready", 0, 72'(pix_ready), 72'(0));
    chk_idle("post_abort", 4);
    run_tbl(tbl.size());

`ifdef XGS_HISPI_TX_CRC_EN
    // single line, two beats: lane 0 gets 0F0 then 00F, check word 0FF
    cfg_lines = 12'd1; cfg_words = 10'd2; cfg_hblank = 8'd0;
    build_frame(1, 2, 0, -1, 0);
    for (int k = 0; k < 6; k++) begin
      tbl[4].pix[k*12 +: 12]  = 12'h0F0 | 12'(k << 8);
      tbl[5].pix[k*12 +: 12]  = 12'h00F;
      tbl[10].exp[k*12 +: 12] = 12'h0FF | 12'(k << 8);
    end
    tbl[4].exp = tbl[4].pix;
    tbl[5].exp = tbl[5].pix;
    run_tbl(tbl.size());
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
